home_inventory_wb_regs: RTL and testbench

//  Wishbone-slave register block for the home-inventory chip (Caravel user-project wrapper side).

---
 rtl/home_inventory_wb_regs.sv | 152 +++++++++++++++
 tb/tb_home_inventory_wb_regs.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/home_inventory_wb_regs.sv
// Wishbone slave register block for the home-inventory chip: ID/version, control, ADC config/snapshot, calibration.
// Build option HOME_INVENTORY_SNAP_CNT_EN maps the snapshot counter read-only at 0x208.
module home_inventory_wb_regs (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  core_status,
  output logic        ctrl_enable,
  output logic        ctrl_start,
  output logic [2:0]  irq_en
);

  localparam logic [31:0] ID_VAL    = 32'h4849_4348;
  localparam logic [31:0] VER_VAL   = 32'h0000_0001;
  localparam logic [31:0] SCALE_RST = 32'h0001_0000;

  // Word indices (byte address >> 2)
  localparam logic [9:0] A_ID     = 10'h000;
  localparam logic [9:0] A_VER    = 10'h001;
  localparam logic [9:0] A_CTRL   = 10'h040;
  localparam logic [9:0] A_IRQ    = 10'h041;
  localparam logic [9:0] A_STATUS = 10'h042;
  localparam logic [9:0] A_CFG    = 10'h080;
  localparam logic [9:0] A_CMD    = 10'h081;
  localparam logic [9:0] A_SNAP   = 10'h082;
  localparam logic [7:0] G_RAW    = 8'h21;
  localparam logic [7:0] G_TARE   = 8'h30;
  localparam logic [7:0] G_SCALE  = 8'h32;

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_ctrl_en;
  logic        r_start;
  logic [2:0]  r_irq_en;
  logic [3:0]  r_num_ch;
  logic [11:0] r_snap_cnt;
  logic [15:0] r_raw   [4];
  logic [31:0] r_tare  [4];
  logic [31:0] r_scale [4];

  logic        w_req;
  logic        w_wr;
  logic [9:0]  w_idx;
  logic [1:0]  w_ch;
  logic [11:0] w_snap_next;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_req         = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr          = w_req & wbs_we_i;
  assign w_idx         = wbs_adr_i[11:2];
  assign w_ch          = wbs_adr_i[3:2];
  assign w_snap_next   = r_snap_cnt + 12'd1;
  assign w_unused_addr = ^{wbs_adr_i[31:12], wbs_adr_i[1:0]};

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Read-data mux; anything not decoded reads zero
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_idx)
      A_ID:     w_rdata = ID_VAL;
      A_VER:    w_rdata = VER_VAL;
      A_CTRL:   w_rdata = {31'h0, r_ctrl_en};
      A_IRQ:    w_rdata = {29'h0, r_irq_en};
      A_STATUS: w_rdata = {24'h0, core_status};
      A_CFG:    w_rdata = {28'h0, r_num_ch};
`ifdef HOME_INVENTORY_SNAP_CNT_EN
      A_SNAP:   w_rdata = {20'h0, r_snap_cnt};
`endif
      default: begin
        if (w_idx[9:2] == G_RAW) begin
          w_rdata = {16'h0, r_raw[w_ch]};
        end else if (w_idx[9:2] == G_TARE) begin
          w_rdata = r_tare[w_ch];
        end else if (w_idx[9:2] == G_SCALE) begin
          w_rdata = r_scale[w_ch];
        end else begin
          w_rdata = 32'h0000_0000;
        end
      end
    endcase
  end

  // Bus handshake, register writes and snapshot update
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_rdata    <= 32'h0000_0000;
      r_ctrl_en  <= 1'b0;
      r_start    <= 1'b0;
      r_irq_en   <= 3'b000;
      r_num_ch   <= 4'h0;
      r_snap_cnt <= 12'h000;
      for (int k = 0; k < 4; k++) begin
        r_raw[k]   <= 16'h0000;
        r_tare[k]  <= 32'h0000_0000;
        r_scale[k] <= SCALE_RST;
      end
    end else begin
      r_ack   <= w_req;
      r_start <= 1'b0;
      if (w_req) r_rdata <= w_rdata;
      if (w_wr) begin
        case (w_idx)
          A_CTRL: begin
            if (wbs_sel_i[0]) begin
              r_ctrl_en <= wbs_dat_i[0];
              r_start   <= wbs_dat_i[1];
            end
          end
          A_IRQ: if (wbs_sel_i[0]) r_irq_en <= wbs_dat_i[2:0];
          A_CFG: if (wbs_sel_i[0]) r_num_ch <= wbs_dat_i[3:0];
          A_CMD: begin
            if (wbs_sel_i[0] && wbs_dat_i[0]) begin
              r_snap_cnt <= w_snap_next;
              for (int k = 0; k < 4; k++) r_raw[k] <= {4'(k + 1), w_snap_next};
            end
          end
          default: begin
            if (w_idx[9:2] == G_TARE) begin
              r_tare[w_ch] <= f_merge(r_tare[w_ch], wbs_dat_i, wbs_sel_i);
            end else if (w_idx[9:2] == G_SCALE) begin
              r_scale[w_ch] <= f_merge(r_scale[w_ch], wbs_dat_i, wbs_sel_i);
            end
          end
        endcase
      end
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_rdata;
  assign ctrl_enable = r_ctrl_en;
  assign ctrl_start  = r_start;
  assign irq_en      = r_irq_en;

endmodule

// File: tb/tb_home_inventory_wb_regs.sv
// Table-driven bench for home_inventory_wb_regs plus hand sequences for START pulse and mid-access reset.
module tb_home_inventory_wb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  core_status;
  logic        ctrl_enable, ctrl_start;
  logic [2:0]  irq_en;

  int tests = 0;
  int failed = 0;

  home_inventory_wb_regs dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .core_status(core_status), .ctrl_enable(ctrl_enable), .ctrl_start(ctrl_start), .irq_en(irq_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
    logic        en;
    logic [2:0]  irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] e, input logic en, input logic [2:0] iq);
    vec_t v;
    v.name = n; v.we = w; v.adr = a; v.sel = s; v.dat = d; v.exp = e; v.en = en; v.irq = iq;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the acking edge
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    rd = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tests++;
    if (!got) begin
      failed++;
      $display("FAIL ack_timeout: got no ack expected ack at addr %h", a);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] snap_exp;

  initial begin
`ifdef HOME_INVENTORY_SNAP_CNT_EN
    snap_exp = 32'h0000_0002;
`else
    snap_exp = 32'h0000_0000;
`endif
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    dat_i = 32'h0; adr = 32'h0; core_status = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_enable", {31'h0, ctrl_enable}, 32'h0);
    check("rst_start", {31'h0, ctrl_start}, 32'h0);
    check("rst_irq", {29'h0, irq_en}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    add("id",          1'b0, 32'h000, 4'hF, 32'h0,        32'h4849_4348, 1'b0, 3'd0);
    add("id_alias",    1'b0, 32'h1000, 4'hF, 32'h0,       32'h4849_4348, 1'b0, 3'd0);
    add("version",     1'b0, 32'h004, 4'hF, 32'h0,        32'h0000_0001, 1'b0, 3'd0);
    add("status",      1'b0, 32'h108, 4'hF, 32'h0,        32'h0000_00A5, 1'b0, 3'd0);
    add("ctrl_wr1",    1'b1, 32'h100, 4'hF, 32'h1,        32'h0,         1'b1, 3'd0);
    add("ctrl_rd",     1'b0, 32'h102, 4'hF, 32'h0,        32'h0000_0001, 1'b1, 3'd0);
    add("irq_wr_all",  1'b1, 32'h104, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1, 3'd7);
    add("irq_rd7",     1'b0, 32'h104, 4'hF, 32'h0,        32'h0000_0007, 1'b1, 3'd7);
    add("irq_wr5",     1'b1, 32'h104, 4'h1, 32'h5,        32'h0,         1'b1, 3'd5);
    add("irq_rd5",     1'b0, 32'h104, 4'hF, 32'h0,        32'h0000_0005, 1'b1, 3'd5);
    add("cfg_rst",     1'b0, 32'h200, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("cfg_wr",      1'b1, 32'h200, 4'hF, 32'h4,        32'h0,         1'b1, 3'd5);
    add("cfg_rd",      1'b0, 32'h200, 4'hF, 32'h0,        32'h0000_0004, 1'b1, 3'd5);
    add("raw0_rst",    1'b0, 32'h210, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("cmd_rd",      1'b0, 32'h204, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("snap1",       1'b1, 32'h204, 4'hF, 32'h1,        32'h0,         1'b1, 3'd5);
    add("raw0_s1",     1'b0, 32'h210, 4'hF, 32'h0,        32'h0000_1001, 1'b1, 3'd5);
    add("snap_zero",   1'b1, 32'h204, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("snap2",       1'b1, 32'h204, 4'h1, 32'h1,        32'h0,         1'b1, 3'd5);
    add("snap_nosel",  1'b1, 32'h204, 4'hE, 32'h1,        32'h0,         1'b1, 3'd5);
    add("raw0_s2",     1'b0, 32'h210, 4'hF, 32'h0,        32'h0000_1002, 1'b1, 3'd5);
    add("raw1_s2",     1'b0, 32'h214, 4'hF, 32'h0,        32'h0000_2002, 1'b1, 3'd5);
    add("raw3_s2",     1'b0, 32'h21C, 4'hF, 32'h0,        32'h0000_4002, 1'b1, 3'd5);
    add("snap_cnt",    1'b0, 32'h208, 4'hF, 32'h0,        snap_exp,      1'b1, 3'd5);
    add("scale0_rst",  1'b0, 32'h320, 4'hF, 32'h0,        32'h0001_0000, 1'b1, 3'd5);
    add("scale3_rst",  1'b0, 32'h32C, 4'hF, 32'h0,        32'h0001_0000, 1'b1, 3'd5);
    add("tare_lo",     1'b1, 32'h300, 4'h3, 32'h0000_BEEF, 32'h0,        1'b1, 3'd5);
    add("tare_hi",     1'b1, 32'h300, 4'hC, 32'hDEAD_0000, 32'h0,        1'b1, 3'd5);
    add("tare_rd",     1'b0, 32'h300, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b1, 3'd5);
    add("tare1_rd",    1'b0, 32'h304, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("evt_wr",      1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1, 3'd5);
    add("evt_rd",      1'b0, 32'h400, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);
    add("unmap_wr",    1'b1, 32'h7FC, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1, 3'd5);
    add("unmap_rd",    1'b0, 32'h7FC, 4'hF, 32'h0,        32'h0,         1'b1, 3'd5);

    foreach (vecs[i]) begin
      wb_access(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd);
      if (!vecs[i].we) check({vecs[i].name, "_data"}, rd, vecs[i].exp);
      check({vecs[i].name, "_en"}, {31'h0, ctrl_enable}, {31'h0, vecs[i].en});
      check({vecs[i].name, "_irq"}, {29'h0, irq_en}, {29'h0, vecs[i].irq});
      @(posedge clk); #1;
      check({vecs[i].name, "_ack_drop"}, {31'h0, ack}, 32'h0);
    end

    // START with ENABLE: one-cycle pulse, enable level kept
    wb_access(1'b1, 32'h100, 4'h1, 32'h3, rd);
    check("start_hi", {31'h0, ctrl_start}, 32'h1);
    @(posedge clk); #1;
    check("start_lo", {31'h0, ctrl_start}, 32'h0);
    check("start_en", {31'h0, ctrl_enable}, 32'h1);
    wb_access(1'b1, 32'h100, 4'h2, 32'h3, rd);
    check("start_nosel", {31'h0, ctrl_start}, 32'h0);
    @(posedge clk); #1;
    wb_access(1'b0, 32'h100, 4'hF, 32'h0, rd);
    check("ctrl_start_rd0", rd, 32'h0000_0001);
    @(posedge clk); #1;

    // Reset arriving with a pending write drops it
    wb_access(1'b1, 32'h304, 4'hF, 32'h1234_5678, rd);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h304; sel = 4'hF; dat_i = 32'hAAAA_AAAA;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", {31'h0, ack}, 32'h0);
    check("midrst_en", {31'h0, ctrl_enable}, 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    wb_access(1'b0, 32'h304, 4'hF, 32'h0, rd);
    check("midrst_tare1", rd, 32'h0);
    @(posedge clk); #1;
    wb_access(1'b0, 32'h210, 4'hF, 32'h0, rd);
    check("midrst_raw0", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
